tl_ram_ctrl: RTL

TileLink-UL slave controller that sits in front of the byte-array `RAM` and is the only initiator of its ports. It accepts Get, PutFullData and PutPartialData on channel A and drives the RAM's write and read ports with registered sequencing. The RAM has no byte enables, so the block performs read-modify-write for sub-word or masked writes. It returns AccessAck or AccessAckData on channel D, with `d_denied` for illegal requests.

---
 rtl/tl_ram_ctrl.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tl_ram_ctrl.sv
// tl_ram_ctrl: TileLink-UL slave sitting in front of a byte-addressed RAM that
// has no byte enables. Handles Get, PutFullData and PutPartialData, one request
// at a time, and answers with AccessAck / AccessAckData (d_denied on illegal
// requests).
// Optional feature macro: TL_RAM_RMW_EN
//   defined   -> sub-word / masked Puts are done as read-modify-write.
//   undefined -> any Put other than a full 64-bit, all-lanes write is denied.
module tl_ram_ctrl #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned SRC_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  // channel A
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [2:0]       a_opcode,
  input  logic [2:0]       a_size,
  input  logic [SRC_W-1:0] a_source,
  input  logic [31:0]      a_address,
  input  logic [7:0]       a_mask,
  input  logic [63:0]      a_data,
  // channel D
  output logic             d_valid,
  input  logic             d_ready,
  output logic [2:0]       d_opcode,
  output logic [2:0]       d_size,
  output logic [SRC_W-1:0] d_source,
  output logic             d_denied,
  output logic [63:0]      d_data,
  // RAM ports
  output logic             ram_wen,
  output logic [31:0]      ram_waddr,
  output logic [63:0]      ram_wdata,
  output logic             ram_ren,
  output logic [31:0]      ram_raddr,
  input  logic [63:0]      ram_rdata
);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] D_ACK       = 3'd0;
  localparam logic [2:0] D_ACK_DATA  = 3'd1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               d_valid_q, d_valid_d;
  logic               d_denied_q, d_denied_d;
  logic [2:0]         d_opcode_q, d_opcode_d;
  logic [2:0]         d_size_q, d_size_d;
  logic [SRC_W-1:0]   d_source_q, d_source_d;
  logic [63:0]        d_data_q, d_data_d;
  logic               ram_wen_q, ram_wen_d;
  logic               ram_ren_q, ram_ren_d;
  logic [31:0]        ram_addr_q, ram_addr_d;
  logic [63:0]        ram_wdata_q, ram_wdata_d;

`ifdef TL_RAM_RMW_EN
  logic [7:0]         mask_q, mask_d;
  logic [63:0]        data_q, data_d;
  logic [63:0]        merged_c;
`endif

  logic               misalign_c;
  logic               legal_op_c;
  logic               is_get_c;
  logic               is_full_c;
  logic               denied_c;

  // Alignment of the byte address to the transfer size
  always_comb begin
    misalign_c = 1'b0;
    case (a_size)
      3'd1:    misalign_c = a_address[0];
      3'd2:    misalign_c = |a_address[1:0];
      3'd3:    misalign_c = |a_address[2:0];
      default: misalign_c = 1'b0;
    endcase
  end

  // Request classification and legality
  always_comb begin
    legal_op_c = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART) ||
                 (a_opcode == OP_GET);
    is_get_c   = (a_opcode == OP_GET);
    is_full_c  = (a_opcode == OP_PUT_FULL) && (a_size == 3'd3) && (a_mask == 8'hFF);
    denied_c   = !legal_op_c || (a_size > 3'd3) || misalign_c ||
                 (a_address >= 32'(MEM_BYTES));
`ifndef TL_RAM_RMW_EN
    // Without RMW the RAM can only take whole-word writes
    if (!is_get_c && !is_full_c) denied_c = 1'b1;
`endif
  end

`ifdef TL_RAM_RMW_EN
  // Lane merge of latched write data over the old RAM word
  always_comb begin
    merged_c = ram_rdata;
    for (int i = 0; i < 8; i++) begin
      if (mask_q[i]) merged_c[8*i +: 8] = data_q[8*i +: 8];
    end
  end
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    d_valid_d   = d_valid_q;
    d_denied_d  = d_denied_q;
    d_opcode_d  = d_opcode_q;
    d_size_d    = d_size_q;
    d_source_d  = d_source_q;
    d_data_d    = d_data_q;
    ram_wen_d   = 1'b0;
    ram_ren_d   = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
`ifdef TL_RAM_RMW_EN
    mask_d      = mask_q;
    data_d      = data_q;
`endif

    case (state_q)
      IDLE: begin
        if (a_valid) begin
          d_opcode_d = is_get_c ? D_ACK_DATA : D_ACK;
          d_size_d   = a_size;
          d_source_d = a_source;
          d_data_d   = 64'd0;
          d_denied_d = 1'b0;
`ifdef TL_RAM_RMW_EN
          mask_d     = a_mask;
          data_d     = a_data;
`endif
          if (denied_c) begin
            d_denied_d = 1'b1;
            d_valid_d  = 1'b1;
            state_d    = RESP;
          end else if (is_full_c) begin
            ram_addr_d  = {a_address[31:3], 3'b000};
            ram_wdata_d = a_data;
            ram_wen_d   = 1'b1;
            state_d     = WR;
          end else begin
            ram_addr_d = {a_address[31:3], 3'b000};
            ram_ren_d  = 1'b1;
            state_d    = RD_REQ;
          end
        end
      end

      RD_REQ: state_d = RD_WAIT;

      RD_WAIT: begin
`ifdef TL_RAM_RMW_EN
        if (d_opcode_q == D_ACK_DATA) begin
          d_data_d  = ram_rdata;
          d_valid_d = 1'b1;
          state_d   = RESP;
        end else begin
          ram_wdata_d = merged_c;
          ram_wen_d   = 1'b1;
          state_d     = WR;
        end
`else
        d_data_d  = ram_rdata;
        d_valid_d = 1'b1;
        state_d   = RESP;
`endif
      end

      WR: begin
        d_valid_d = 1'b1;
        state_d   = RESP;
      end

      RESP: begin
        if (d_ready) begin
          d_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      d_valid_q   <= 1'b0;
      d_denied_q  <= 1'b0;
      d_opcode_q  <= 3'd0;
      d_size_q    <= 3'd0;
      d_source_q  <= '0;
      d_data_q    <= 64'd0;
      ram_wen_q   <= 1'b0;
      ram_ren_q   <= 1'b0;
      ram_addr_q  <= 32'd0;
      ram_wdata_q <= 64'd0;
`ifdef TL_RAM_RMW_EN
      mask_q      <= 8'd0;
      data_q      <= 64'd0;
`endif
    end else begin
      state_q     <= state_d;
      d_valid_q   <= d_valid_d;
      d_denied_q  <= d_denied_d;
      d_opcode_q  <= d_opcode_d;
      d_size_q    <= d_size_d;
      d_source_q  <= d_source_d;
      d_data_q    <= d_data_d;
      ram_wen_q   <= ram_wen_d;
      ram_ren_q   <= ram_ren_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
`ifdef TL_RAM_RMW_EN
      mask_q      <= mask_d;
      data_q      <= data_d;
`endif
    end
  end

  assign a_ready   = (state_q == IDLE);
  assign d_valid   = d_valid_q;
  assign d_denied  = d_denied_q;
  assign d_opcode  = d_opcode_q;
  assign d_size    = d_size_q;
  assign d_source  = d_source_q;
  assign d_data    = d_data_q;
  assign ram_wen   = ram_wen_q;
  assign ram_ren   = ram_ren_q;
  assign ram_waddr = ram_addr_q;
  assign ram_raddr = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule
